cc_speedlimit_controller: RTL

Sequencer for the speed comparator datapath. It accepts new speed-limit requests over a req/ack handshake and drives the comparator's limit bus and active-low load strobe with guaranteed setup. It then samples the comparator's active-low over-speed output on a periodic tick and filters it through trip/clear counters into a clean alarm. It sits between the system control logic and the comparator instance.

---
 rtl/cc_speedlimit_pkg.sv | 23 ++
 rtl/cc_speedlimit_if.sv | 41 ++++
 rtl/cc_speedlimit_debounce.sv | 36 +++
 rtl/cc_speedlimit_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cc_speedlimit_pkg.sv
// Shared types and constants for the speed-limit sequencer.
// State encoding is exported on the debug bus, so the values are fixed.
package cc_speedlimit_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_MONITOR = 3'd3,
        ST_ALARM   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/cc_speedlimit_if.sv
// Bus between the system control logic (master) and the speed-limit
// sequencer (slave), including the comparator-facing limit/load/over lines.
//
// Handshake: the master raises limitReq with limitNew stable and holds both
// until limitAck pulses for one cycle; req is ignored during that ack cycle,
// and req still high on the cycle after ack is taken as a fresh request.
interface cc_speedlimit_if
    import cc_speedlimit_pkg::*;
#(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] CC_SPEEDLIMIT_limitNew_InBUS;
    logic                 CC_SPEEDLIMIT_limitReq_InHigh;
    logic                 CC_SPEEDLIMIT_limitAck_OutHigh;
    logic                 CC_SPEEDLIMIT_sampleTick_InHigh;
    logic                 CC_SPEEDLIMIT_cmpOver_InLow;
    logic                 CC_SPEEDLIMIT_alarmClear_InHigh;
    logic [DATAWIDTH-1:0] CC_SPEEDLIMIT_limit_OutBUS;
    logic                 CC_SPEEDLIMIT_load_OutLow;
    logic                 CC_SPEEDLIMIT_alarm_OutHigh;
    logic [STATE_W-1:0]   CC_SPEEDLIMIT_state_OutBUS;

    modport master (
        output CC_SPEEDLIMIT_limitNew_InBUS, CC_SPEEDLIMIT_limitReq_InHigh,
               CC_SPEEDLIMIT_sampleTick_InHigh, CC_SPEEDLIMIT_cmpOver_InLow,
               CC_SPEEDLIMIT_alarmClear_InHigh,
        input  CC_SPEEDLIMIT_limitAck_OutHigh, CC_SPEEDLIMIT_limit_OutBUS,
               CC_SPEEDLIMIT_load_OutLow, CC_SPEEDLIMIT_alarm_OutHigh,
               CC_SPEEDLIMIT_state_OutBUS
    );

    modport slave (
        input  CC_SPEEDLIMIT_limitNew_InBUS, CC_SPEEDLIMIT_limitReq_InHigh,
               CC_SPEEDLIMIT_sampleTick_InHigh, CC_SPEEDLIMIT_cmpOver_InLow,
               CC_SPEEDLIMIT_alarmClear_InHigh,
        output CC_SPEEDLIMIT_limitAck_OutHigh, CC_SPEEDLIMIT_limit_OutBUS,
               CC_SPEEDLIMIT_load_OutLow, CC_SPEEDLIMIT_alarm_OutHigh,
               CC_SPEEDLIMIT_state_OutBUS
    );

endinterface

// File: rtl/cc_speedlimit_debounce.sv
// Consecutive-sample counter: counts enabled samples that qualify, restarts
// on a non-qualifying sample, saturates, and flags the sample that reaches
// THRESHOLD combinationally so the caller can act on that same edge.
module cc_speedlimit_debounce
    import cc_speedlimit_pkg::*;
#(
    parameter int THRESHOLD = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sample,
    output logic reached
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = sat_inc(count);
    assign reached   = en && sample && (count_inc >= LIMIT);

    // Count qualifying samples; clear has priority over a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sample ? count_inc : '0;
        end
    end

endmodule

// File: rtl/cc_speedlimit_controller.sv
// Speed-limit sequencer: loads a new limit into the comparator with one
// cycle of setup before the active-low load strobe, then filters the
// comparator's over-speed output into an alarm via trip/clear counters.
// Optional build macro: CC_SPEEDLIMIT_ALARMLATCH_EN makes the alarm sticky
// until alarmClear is pulsed outside the ALARM state.
module cc_speedlimit_controller
    import cc_speedlimit_pkg::*;
#(
    parameter int SPEEDLIMIT_DATAWIDTH  = 8,
    parameter int SPEEDLIMIT_TRIPCOUNT  = 4,
    parameter int SPEEDLIMIT_CLEARCOUNT = 4,
    parameter int SPEEDLIMIT_LOADCYCLES = 2
)
(
    input  logic            CC_SPEEDLIMIT_CLOCK_50,
    input  logic            CC_SPEEDLIMIT_RESET_InLow,
    cc_speedlimit_if.slave  bus
);
    localparam logic [2:0] LOAD_LAST = 3'(SPEEDLIMIT_LOADCYCLES - 1);

    logic clk;
    logic rst_n;
    assign clk   = CC_SPEEDLIMIT_CLOCK_50;
    assign rst_n = CC_SPEEDLIMIT_RESET_InLow;

    state_t                          state;
    state_t                          state_next;
    logic [1:0]                      over_sync;
    logic                            over;
    logic [2:0]                      strobe_cnt;
    logic                            ack_q;
    logic [SPEEDLIMIT_DATAWIDTH-1:0] limit_q;
    logic                            req_take;
    logic                            trip_en;
    logic                            clear_en;
    logic                            trip_clr;
    logic                            clear_clr;
    logic                            trip_hit;
    logic                            clear_hit;

    // The request is not re-accepted while its own ack is still on the bus.
    assign over      = ~over_sync[1];
    assign req_take  = bus.CC_SPEEDLIMIT_limitReq_InHigh && !ack_q;
    assign trip_en   = bus.CC_SPEEDLIMIT_sampleTick_InHigh && (state == ST_MONITOR);
    assign clear_en  = bus.CC_SPEEDLIMIT_sampleTick_InHigh && (state == ST_ALARM);
    assign trip_clr  = (state_next != ST_MONITOR);
    assign clear_clr = (state_next != ST_ALARM);

    cc_speedlimit_debounce #(.THRESHOLD(SPEEDLIMIT_TRIPCOUNT)) u_trip (
        .clk(clk), .rst_n(rst_n), .clr(trip_clr), .en(trip_en),
        .sample(over), .reached(trip_hit)
    );

    cc_speedlimit_debounce #(.THRESHOLD(SPEEDLIMIT_CLEARCOUNT)) u_clear (
        .clk(clk), .rst_n(rst_n), .clr(clear_clr), .en(clear_en),
        .sample(!over), .reached(clear_hit)
    );

    // Next-state decode; a request outranks a sample tick in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (req_take) state_next = ST_SETUP;
            ST_SETUP:   state_next = ST_STROBE;
            ST_STROBE:  if (strobe_cnt == LOAD_LAST) state_next = ST_MONITOR;
            ST_MONITOR: begin
                if (req_take)      state_next = ST_SETUP;
                else if (trip_hit) state_next = ST_ALARM;
            end
            ST_ALARM: begin
                if (req_take)       state_next = ST_SETUP;
                else if (clear_hit) state_next = ST_MONITOR;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // State, strobe timer, ack pulse, limit capture and input synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            strobe_cnt <= '0;
            ack_q      <= 1'b0;
            limit_q    <= '0;
            over_sync  <= 2'b11;
        end else begin
            state      <= state_next;
            strobe_cnt <= (state == ST_STROBE) ? strobe_cnt + 1'b1 : 3'd0;
            ack_q      <= (state == ST_STROBE) && (state_next == ST_MONITOR);
            over_sync  <= {over_sync[0], bus.CC_SPEEDLIMIT_cmpOver_InLow};
            if ((state_next == ST_SETUP) && (state != ST_SETUP)) begin
                limit_q <= bus.CC_SPEEDLIMIT_limitNew_InBUS;
            end
        end
    end

    assign bus.CC_SPEEDLIMIT_limit_OutBUS     = limit_q;
    assign bus.CC_SPEEDLIMIT_load_OutLow      = (state != ST_STROBE);
    assign bus.CC_SPEEDLIMIT_limitAck_OutHigh = ack_q;
    assign bus.CC_SPEEDLIMIT_state_OutBUS     = state;

`ifdef CC_SPEEDLIMIT_ALARMLATCH_EN
    logic alarm_q;

    // Sticky alarm: set on entering ALARM, cleared only outside ALARM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else if (state_next == ST_ALARM) begin
            alarm_q <= 1'b1;
        end else if (bus.CC_SPEEDLIMIT_alarmClear_InHigh && (state != ST_ALARM)) begin
            alarm_q <= 1'b0;
        end
    end

    assign bus.CC_SPEEDLIMIT_alarm_OutHigh = alarm_q;
`else
    logic unused_alarm_clear;
    assign unused_alarm_clear = bus.CC_SPEEDLIMIT_alarmClear_InHigh;
    assign bus.CC_SPEEDLIMIT_alarm_OutHigh = (state == ST_ALARM);
`endif

endmodule
